// File: rtl/keynsham_irq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keynsham_irq_ctrl_if                                             |
// | Purpose  : keynsham data-bus slave port bundle for the interrupt controller |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface keynsham_irq_ctrl_if;
    logic        bus_access;
    logic        bus_cs;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic        bus_wr_en;
    logic [3:0]  bus_bytesel;
    logic        bus_error;
    logic        bus_ack;
    logic [31:0] bus_data;

    modport master (
        output bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
        input  bus_cs, bus_error, bus_ack, bus_data
    );

    modport slave (
        input  bus_access, bus_addr, bus_wr_val, bus_wr_en, bus_bytesel,
        output bus_cs, bus_error, bus_ack, bus_data
    );
endinterface
`default_nettype wire

// File: rtl/keynsham_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : keynsham_irq_ctrl                                                |
// | Purpose  : edge/level interrupt latch, enable mask, registered CPU irq      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module keynsham_irq_ctrl #(
    parameter logic [31:0] BUS_ADDRESS = 32'h0,
    parameter logic [31:0] BUS_SIZE    = 32'h0,
    parameter int          NR_IRQS     = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    keynsham_irq_ctrl_if.slave      bus,
    input  wire logic [NR_IRQS-1:0] irq_in,
    output logic                    irq_out
);

    localparam logic [2:0] c_slot_raw     = 3'd0;
    localparam logic [2:0] c_slot_enable  = 3'd1;
    localparam logic [2:0] c_slot_pending = 3'd2;
    localparam logic [2:0] c_slot_clear   = 3'd3;
    localparam logic [2:0] c_slot_edge    = 3'd4;

    // Bits at and above NR_IRQS are hard-wired to zero in every register.
    localparam logic [31:0] c_valid_mask =
        (NR_IRQS >= 32) ? 32'hFFFF_FFFF : ((32'h1 << NR_IRQS) - 32'h1);

    logic [31:0] r_raw;
    logic [31:0] r_enable;
    logic [31:0] r_edge;
    logic [31:0] r_prev;
    logic        r_ack;
    logic        r_error;
    logic [31:0] r_rd_data;
    logic        r_irq;

    logic [31:0] w_irq;
    logic [32:0] w_byte_addr;
    logic [32:0] w_win_lo;
    logic [32:0] w_win_hi;
    logic        w_cs;
    logic        w_accept;
    logic [2:0]  w_slot;
    logic        w_slot_ok;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_lane_mask;
    logic [31:0] w_wr_data;
    logic [31:0] w_rd_data;
    logic [31:0] w_clr;
    logic [31:0] w_rise;
    logic [31:0] w_raw_next;
    logic [31:0] w_enable_next;
    logic [31:0] w_edge_next;

    generate
        if (NR_IRQS < 32) begin : g_pad
            assign w_irq = {{(32-NR_IRQS){1'b0}}, irq_in};
        end else begin : g_full
            assign w_irq = irq_in;
        end
    endgenerate

    // Window compare done at 33 bits so base+size cannot wrap.
    assign w_byte_addr = {1'b0, bus.bus_addr, 2'b00};
    assign w_win_lo    = {1'b0, BUS_ADDRESS};
    assign w_win_hi    = {1'b0, BUS_ADDRESS} + {1'b0, BUS_SIZE};
    assign w_cs        = (w_byte_addr >= w_win_lo) && (w_byte_addr < w_win_hi);
    assign bus.bus_cs  = w_cs;

    assign w_accept = bus.bus_access & w_cs;
    assign w_slot   = bus.bus_addr[2:0];

    always_comb begin
        w_slot_ok = 1'b0;
        case (w_slot)
            c_slot_raw, c_slot_pending:             w_slot_ok = ~bus.bus_wr_en;
            c_slot_enable, c_slot_clear, c_slot_edge: w_slot_ok = 1'b1;
            default:                                w_slot_ok = 1'b0;
        endcase
    end

    assign w_wr = w_accept &  bus.bus_wr_en & w_slot_ok;
    assign w_rd = w_accept & ~bus.bus_wr_en & w_slot_ok;

    assign w_lane_mask = {{8{bus.bus_bytesel[3]}}, {8{bus.bus_bytesel[2]}},
                          {8{bus.bus_bytesel[1]}}, {8{bus.bus_bytesel[0]}}} & c_valid_mask;
    assign w_wr_data   = bus.bus_wr_val & w_lane_mask;

    always_comb begin
        w_rd_data = 32'h0;
        case (w_slot)
            c_slot_raw:     w_rd_data = r_raw;
            c_slot_enable:  w_rd_data = r_enable;
            c_slot_pending: w_rd_data = r_raw & r_enable;
            c_slot_edge:    w_rd_data = r_edge;
            default:        w_rd_data = 32'h0;
        endcase
    end

    // A rising edge outranks a same-cycle clear, so the OR comes after the mask.
    assign w_clr      = (w_wr && (w_slot == c_slot_clear)) ? w_wr_data : 32'h0;
    assign w_rise     = w_irq & ~r_prev;
    assign w_raw_next = ((r_edge & ((r_raw & ~w_clr) | w_rise)) | (~r_edge & w_irq))
                        & c_valid_mask;

    assign w_enable_next = (w_wr && (w_slot == c_slot_enable))
                           ? ((r_enable & ~w_lane_mask) | w_wr_data) : r_enable;
    assign w_edge_next   = (w_wr && (w_slot == c_slot_edge))
                           ? ((r_edge & ~w_lane_mask) | w_wr_data) : r_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw     <= 32'h0;
            r_enable  <= 32'h0;
            r_edge    <= 32'h0;
            r_prev    <= 32'h0;
            r_ack     <= 1'b0;
            r_error   <= 1'b0;
            r_rd_data <= 32'h0;
            r_irq     <= 1'b0;
        end else begin
            r_raw     <= w_raw_next;
            r_enable  <= w_enable_next;
            r_edge    <= w_edge_next;
            r_prev    <= w_irq & c_valid_mask;
            r_ack     <= w_accept & w_slot_ok;
            r_error   <= w_accept & ~w_slot_ok;
            r_rd_data <= w_rd ? w_rd_data : 32'h0;
            r_irq     <= |(r_raw & r_enable);
        end
    end

    assign bus.bus_ack   = r_ack;
    assign bus.bus_error = r_error;
    assign bus.bus_data  = r_rd_data;
    assign irq_out       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_keynsham_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_keynsham_irq_ctrl                                             |
// | Purpose  : scoreboard bench for keynsham_irq_ctrl against a per-line model  |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_keynsham_irq_ctrl;

    localparam logic [31:0] BUS_ADDRESS = 32'h4000_0100;
    localparam logic [31:0] BUS_SIZE    = 32'h0000_0020;
    localparam int          NR_IRQS     = 32;
    localparam logic [29:0] c_base_w    = BUS_ADDRESS[31:2];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq_in;
    logic        irq_out;

    keynsham_irq_ctrl_if bus ();

    keynsham_irq_ctrl #(
        .BUS_ADDRESS (BUS_ADDRESS),
        .BUS_SIZE    (BUS_SIZE),
        .NR_IRQS     (NR_IRQS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference state: one bit per line, updated by the rules line by line.
    logic [31:0] m_raw, m_en, m_edge, m_prev;
    logic        m_irq_out;

    function automatic logic in_window(input logic [29:0] a);
        longint b;
        b = longint'({a, 2'b00});
        return (b >= longint'(BUS_ADDRESS)) && (b < longint'(BUS_ADDRESS) + longint'(BUS_SIZE));
    endfunction

    task automatic model_reset();
        m_raw = '0; m_en = '0; m_edge = '0; m_prev = '0; m_irq_out = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] lanes, raw_n, rd;
        int          slot;
        logic        accepted, legal, wr_ok, next_irq;
        slot     = int'(bus.bus_addr[2:0]);
        accepted = bus.bus_access && in_window(bus.bus_addr);
        lanes    = '0;
        for (int b = 0; b < 4; b++)
            if (bus.bus_bytesel[b]) lanes[8*b +: 8] = 8'hFF;
        legal = bus.bus_wr_en ? (slot == 1 || slot == 3 || slot == 4) : (slot <= 4);
        wr_ok = accepted && bus.bus_wr_en && legal;
        if (accepted) begin
            rd = '0;
            if (legal && !bus.bus_wr_en) begin
                if (slot == 0) rd = m_raw;
                if (slot == 1) rd = m_en;
                if (slot == 2) rd = m_raw & m_en;
                if (slot == 4) rd = m_edge;
            end
            sb.push_back(resp_t'{ack: legal, err: !legal, data: rd});
        end
        next_irq = ((m_raw & m_en) != 32'h0);
        for (int i = 0; i < NR_IRQS; i++) begin
            if (!m_edge[i]) begin
                raw_n[i] = irq_in[i];
            end else if (irq_in[i] && !m_prev[i]) begin
                raw_n[i] = 1'b1;
            end else if (wr_ok && slot == 3 && lanes[i] && bus.bus_wr_val[i]) begin
                raw_n[i] = 1'b0;
            end else begin
                raw_n[i] = m_raw[i];
            end
        end
        if (wr_ok && slot == 1) m_en   = (m_en   & ~lanes) | (bus.bus_wr_val & lanes);
        if (wr_ok && slot == 4) m_edge = (m_edge & ~lanes) | (bus.bus_wr_val & lanes);
        m_prev    = irq_in;
        m_raw     = raw_n;
        m_irq_out = next_irq;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    // Monitor: every response is due exactly one cycle after acceptance.
    always @(negedge clk) begin
        resp_t e;
        check("irq_out", {31'h0, irq_out}, {31'h0, m_irq_out});
        check("bus_cs", {31'h0, bus.bus_cs}, {31'h0, in_window(bus.bus_addr)});
        if (!rst_n) begin
            check("reset_resp", {bus.bus_ack, bus.bus_error, bus.bus_data[29:0]}, 32'h0);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check("ack",   {31'h0, bus.bus_ack},   {31'h0, e.ack});
            check("error", {31'h0, bus.bus_error}, {31'h0, e.err});
            check("data",  bus.bus_data, e.data);
        end else begin
            check("idle_resp", {bus.bus_ack, bus.bus_error, bus.bus_data[29:0]}, 32'h0);
        end
    end

    // Callers sit 1 time unit after a rising edge; so do these on return.
    task automatic bus_op(input logic wr, input logic [2:0] slot,
                          input logic [31:0] d, input logic [3:0] be);
        bus.bus_access  = 1'b1;
        bus.bus_wr_en   = wr;
        bus.bus_addr    = c_base_w | {27'h0, slot};
        bus.bus_wr_val  = d;
        bus.bus_bytesel = be;
        @(posedge clk); #1;
        bus.bus_access  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.bus_access  = 1'b0;
        bus.bus_wr_en   = 1'b0;
        bus.bus_addr    = c_base_w;
        bus.bus_wr_val  = '0;
        bus.bus_bytesel = '0;
        irq_in          = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int s = 0; s < 5; s++) bus_op(1'b0, 3'(s), 32'h0, 4'h0);

        bus_op(1'b1, 3'd4, 32'h0, 4'hF);
        bus_op(1'b1, 3'd1, 32'h1, 4'hF);
        irq_in[0] = 1'b1;
        idle(4);
        irq_in[0] = 1'b0;
        idle(4);

        do_reset();
        bus_op(1'b1, 3'd4, 32'h2, 4'hF);
        bus_op(1'b1, 3'd1, 32'h2, 4'hF);
        irq_in[1] = 1'b1;
        idle(1);
        irq_in[1] = 1'b0;
        idle(3);
        bus_op(1'b0, 3'd0, 32'h0, 4'h0);
        bus_op(1'b0, 3'd2, 32'h0, 4'h0);
        bus_op(1'b1, 3'd3, 32'h2, 4'hF);
        idle(3);
        bus_op(1'b0, 3'd0, 32'h0, 4'h0);

        bus_op(1'b1, 3'd4, 32'hA, 4'hF);
        bus_op(1'b1, 3'd1, 32'h8, 4'hF);
        irq_in[3] = 1'b1;
        bus_op(1'b1, 3'd3, 32'h8, 4'hF);
        idle(2);
        bus_op(1'b0, 3'd0, 32'h0, 4'h0);
        irq_in[3] = 1'b0;

        bus_op(1'b1, 3'd1, 32'hFFFF_FFFF, 4'b0001);
        bus_op(1'b0, 3'd1, 32'h0, 4'h0);

        bus_op(1'b1, 3'd0, 32'h1234_5678, 4'hF);
        bus_op(1'b0, 3'd6, 32'h0, 4'h0);
        bus_op(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF);
        bus_op(1'b0, 3'd0, 32'h0, 4'h0);
        bus_op(1'b0, 3'd4, 32'h0, 4'h0);

        // Reset lands while the ack pulse of this read is on the bus.
        bus_op(1'b0, 3'd1, 32'h0, 4'h0);
        do_reset();
        idle(2);

        bus_op(1'b1, 3'd4, $urandom, 4'hF);
        bus_op(1'b1, 3'd1, $urandom, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            irq_in = irq_in ^ ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) begin
                bus.bus_access  = 1'b1;
                bus.bus_wr_en   = 1'($urandom_range(0, 1));
                bus.bus_addr    = c_base_w - 30'd2 + 30'($urandom_range(0, 11));
                bus.bus_wr_val  = $urandom;
                bus.bus_bytesel = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #1;
            bus.bus_access = 1'b0;
        end
        irq_in = '0;
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
